// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX stage boundary bundle: ID-side control/operand inputs and their EX-side registered copies.
// Optional macro ID_EX_PC_EN adds the PC+4 field and the bubble counter readout.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall_i;
    logic              flush_i;
    logic              RegDst_i;
    logic              Branch_i;
    logic              MemRead_i;
    logic              MemtoReg_i;
    logic [1:0]        ALUOp_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic              RegWrite_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] Imm_i;
    logic [REG_AW-1:0] RSaddr_i;
    logic [REG_AW-1:0] RTaddr_i;
    logic [REG_AW-1:0] RDaddr_i;
    logic [5:0]        Funct_i;

    logic              RegDst_o;
    logic              Branch_o;
    logic              MemRead_o;
    logic              MemtoReg_o;
    logic [1:0]        ALUOp_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic              RegWrite_o;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] Imm_o;
    logic [REG_AW-1:0] RSaddr_o;
    logic [REG_AW-1:0] RTaddr_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic [5:0]        Funct_o;
    logic              valid_o;
`ifdef ID_EX_PC_EN
    logic [DATA_W-1:0] PCplus4_i;
    logic [DATA_W-1:0] PCplus4_o;
    logic [15:0]       BubbleCnt_o;
`endif

    modport master (
        output stall_i, flush_i, RegDst_i, Branch_i, MemRead_i, MemtoReg_i, ALUOp_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, RSdata_i, RTdata_i, Imm_i,
               RSaddr_i, RTaddr_i, RDaddr_i, Funct_i,
`ifdef ID_EX_PC_EN
               PCplus4_i,
        input  PCplus4_o, BubbleCnt_o,
`endif
        input  RegDst_o, Branch_o, MemRead_o, MemtoReg_o, ALUOp_o, MemWrite_o,
               ALUSrc_o, RegWrite_o, RSdata_o, RTdata_o, Imm_o, RSaddr_o,
               RTaddr_o, RDaddr_o, Funct_o, valid_o
    );

    modport slave (
        input  stall_i, flush_i, RegDst_i, Branch_i, MemRead_i, MemtoReg_i, ALUOp_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, RSdata_i, RTdata_i, Imm_i,
               RSaddr_i, RTaddr_i, RDaddr_i, Funct_i,
`ifdef ID_EX_PC_EN
               PCplus4_i,
        output PCplus4_o, BubbleCnt_o,
`endif
        output RegDst_o, Branch_o, MemRead_o, MemtoReg_o, ALUOp_o, MemWrite_o,
               ALUSrc_o, RegWrite_o, RSdata_o, RTdata_o, Imm_o, RSaddr_o,
               RTaddr_o, RDaddr_o, Funct_o, valid_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hazard-unit stall (hold) and flush (bubble) control.
// Optional macro ID_EX_PC_EN carries PC+4 and exposes the saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    id_ex_pipe_reg_if.slave  bus
);
`ifdef ID_EX_PC_EN
    localparam int PAY_W = 9 + 4 * DATA_W + 3 * REG_AW + 6;
`else
    localparam int PAY_W = 9 + 3 * DATA_W + 3 * REG_AW + 6;
`endif

    logic [PAY_W-1:0] payload_in;
    logic [PAY_W-1:0] payload_d, payload_q;
    logic             valid_d, valid_q;

    // All fields travel as one word so flush/stall/load treat them identically.
    assign payload_in = {bus.RegDst_i, bus.Branch_i, bus.MemRead_i, bus.MemtoReg_i,
                         bus.ALUOp_i, bus.MemWrite_i, bus.ALUSrc_i, bus.RegWrite_i,
                         bus.RSdata_i, bus.RTdata_i, bus.Imm_i,
                         bus.RSaddr_i, bus.RTaddr_i, bus.RDaddr_i, bus.Funct_i
`ifdef ID_EX_PC_EN
                         , bus.PCplus4_i
`endif
                        };

    always_comb begin
        payload_d = payload_q;
        valid_d   = valid_q;
        if (bus.flush_i) begin
            payload_d = '0;
            valid_d   = 1'b0;
        end else if (!bus.stall_i) begin
            payload_d = payload_in;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            payload_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            payload_q <= payload_d;
            valid_q   <= valid_d;
        end
    end

    assign {bus.RegDst_o, bus.Branch_o, bus.MemRead_o, bus.MemtoReg_o,
            bus.ALUOp_o, bus.MemWrite_o, bus.ALUSrc_o, bus.RegWrite_o,
            bus.RSdata_o, bus.RTdata_o, bus.Imm_o,
            bus.RSaddr_o, bus.RTaddr_o, bus.RDaddr_o, bus.Funct_o
`ifdef ID_EX_PC_EN
            , bus.PCplus4_o
`endif
           } = payload_q;
    assign bus.valid_o = valid_q;

`ifdef ID_EX_PC_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush_i && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            bubble_cnt_q <= '0;
        else
            bubble_cnt_q <= bubble_cnt_d;
    end

    assign bus.BubbleCnt_o = bubble_cnt_q;
`endif
endmodule
